// File: rtl/delta_liafn_pkg.sv
// Shared types for the delta-spiking neuron scheduler: FSM encoding, default
// datapath width and the event record passed to readout logic.
package delta_liafn_pkg;

  localparam int W_DEFAULT = 8;
  localparam int IDX_W_MAX = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_UPDATE,
    S_EMIT,
    S_DONE
  } fsm_state_t;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic [W_DEFAULT-1:0] delta;
  } event_t;

endpackage

// File: rtl/delta_neuron_update.sv
// Combinational leaky-integrate step for one neuron: leak, add current,
// saturate, then measure the change against the last reported value.
module delta_neuron_update
  import delta_liafn_pkg::*;
#(
  parameter int W            = W_DEFAULT,
  parameter int DELTA_THRESH = 10,
  parameter int LEAK_SHIFT   = 2
) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] last,
  output logic [W-1:0] new_s,
  output logic [W-1:0] delta,
  output logic         spike
);

  localparam logic signed [W:0] THRESH = (W+1)'(DELTA_THRESH);

  logic [W-1:0]        leak;
  logic [W-1:0]        kept;
  logic [W:0]          sum;
  logic signed [W:0]   diff;

  always_comb begin
    leak  = s >> LEAK_SHIFT;
    kept  = s - leak;
    sum   = {1'b0, kept} + {1'b0, cur};
    new_s = sum[W] ? {W{1'b1}} : sum[W-1:0];
    // Extra sign bit keeps a decaying membrane from looking like a large positive change
    diff  = $signed({1'b0, new_s}) - $signed({1'b0, last});
    delta = diff[W-1:0];
    spike = (diff >= THRESH);
  end

endmodule

// File: rtl/delta_neuron_scheduler.sv
// Sweeps N virtual neurons through one shared update datapath per timestep
// and emits (index, delta) events over a valid/ready port.
module delta_neuron_scheduler
  import delta_liafn_pkg::*;
#(
  parameter int N_NEURONS    = 4,
  parameter int W            = W_DEFAULT,
  parameter int DELTA_THRESH = 10,
  parameter int LEAK_SHIFT   = 2,
  parameter int IDX_W        = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [IDX_W-1:0] cur_idx,
  input  logic [W-1:0]     cur_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [IDX_W-1:0] ev_idx,
  output logic [W-1:0]     ev_delta,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [W-1:0]     dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  fsm_state_t       fsm_reg, fsm_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [W-1:0]     s_reg, cur_reg;
  logic             ev_valid_reg;
  logic [IDX_W-1:0] ev_idx_reg;
  logic [W-1:0]     ev_delta_reg;
  logic             overrun_reg;

  logic [W-1:0]     state_mem [N_NEURONS];
  logic [W-1:0]     last_mem  [N_NEURONS];

  logic [W-1:0]     new_s;
  logic [W-1:0]     delta;
  logic             spike;
  logic             handshake;

  delta_neuron_update #(
    .W            (W),
    .DELTA_THRESH (DELTA_THRESH),
    .LEAK_SHIFT   (LEAK_SHIFT)
  ) u_update (
    .s     (s_reg),
    .cur   (cur_reg),
    .last  (last_mem[idx_reg]),
    .new_s (new_s),
    .delta (delta),
    .spike (spike)
  );

  assign handshake = ev_valid_reg && ev_ready;

  always_comb begin
    fsm_next = fsm_reg;
    idx_next = idx_reg;
    case (fsm_reg)
      S_IDLE: begin
        if (step) begin
          fsm_next = S_FETCH;
          idx_next = '0;
        end
      end
      S_FETCH: fsm_next = S_UPDATE;
      S_UPDATE: begin
        if (spike) begin
          fsm_next = S_EMIT;
        end else if (idx_reg == LAST_IDX) begin
          fsm_next = S_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
          fsm_next = S_FETCH;
        end
      end
      S_EMIT: begin
        if (handshake) begin
          if (idx_reg == LAST_IDX) begin
            fsm_next = S_DONE;
          end else begin
            idx_next = idx_reg + 1'b1;
            fsm_next = S_FETCH;
          end
        end
      end
      S_DONE: begin
        fsm_next = S_IDLE;
        idx_next = '0;
      end
      default: begin
        fsm_next = S_IDLE;
        idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg      <= S_IDLE;
      idx_reg      <= '0;
      s_reg        <= '0;
      cur_reg      <= '0;
      ev_valid_reg <= 1'b0;
      ev_idx_reg   <= '0;
      ev_delta_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      fsm_reg <= fsm_next;
      idx_reg <= idx_next;
      if (fsm_reg == S_FETCH) begin
        s_reg   <= state_mem[idx_reg];
        cur_reg <= cur_in;
      end
      if (fsm_reg == S_UPDATE && spike) begin
        ev_valid_reg <= 1'b1;
        ev_idx_reg   <= idx_reg;
        ev_delta_reg <= delta;
      end else if (fsm_reg == S_EMIT && handshake) begin
        ev_valid_reg <= 1'b0;
      end
      // Any strobe outside IDLE (DONE included) is dropped but remembered
      if (step && fsm_reg != S_IDLE) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      logic [W-1:0] state_q;
      logic [W-1:0] last_q;
      logic         wr_en;

      assign wr_en = (fsm_reg == S_UPDATE) && (idx_reg == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= '0;
          last_q  <= '0;
        end else if (wr_en) begin
          state_q <= new_s;
          if (spike) begin
            last_q <= new_s;
          end
        end
      end

      assign state_mem[gi] = state_q;
      assign last_mem[gi]  = last_q;
    end
  endgenerate

  assign cur_idx   = idx_reg;
  assign ev_valid  = ev_valid_reg;
  assign ev_idx    = ev_idx_reg;
  assign ev_delta  = ev_delta_reg;
  assign busy      = (fsm_reg != S_IDLE);
  assign done      = (fsm_reg == S_DONE);
  assign overrun   = overrun_reg;
  assign dbg_state = state_mem[idx_reg];

endmodule

// File: doc/delta_neuron_scheduler.md
# delta_neuron_scheduler

Time-multiplexed controller that shares one leaky-integrate delta-spiking update datapath among `N_NEURONS` virtual neurons. On each timestep strobe it walks the neurons in index order, fetches each neuron's input current, updates its membrane state, and compares the new state against the state last reported. When the change reaches the delta threshold it emits an event (index, delta) on a valid/ready port. It sits between the chip input pins (current source) and the event output/readout logic.

## Interface
- `N_NEURONS`, 4: number of virtual neurons, 2..16.
- `W`, 8: state/current/delta width.
- `DELTA_THRESH`, 10: minimum positive delta that produces an event.
- `LEAK_SHIFT`, 2: leak is `state >> LEAK_SHIFT`.
- `IDX_W`, $clog2(N_NEURONS): index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `step` in 1: timestep strobe, sampled only in IDLE.
- `cur_idx` out IDX_W: neuron whose current is requested.
- `cur_in` in W: unsigned current for `cur_idx`, valid in the FETCH cycle.
- `ev_valid` out 1: event available.
- `ev_ready` in 1: consumer accepts the event.
- `ev_idx` out IDX_W: event neuron index.
- `ev_delta` out W: event delta, positive, `>= DELTA_THRESH`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at sweep end.
- `overrun` out 1: sticky; `step` arrived while busy.
- `dbg_state` out W: state of neuron `cur_idx`, for pin readout.

## Operation
- FSM states:
  - IDLE: `step` -> FETCH with i=0.
  - FETCH: register `cur_in` and `state[i]` -> UPDATE.
  - UPDATE: compute and write `state[i]`. On a spike -> EMIT. Otherwise, if i<N-1 then i++ and -> FETCH, else -> DONE.
  - EMIT: hold the event until `ev_valid && ev_ready`, then advance as UPDATE does.
  - DONE: `done`=1 -> IDLE.
- Arithmetic (unsigned W-bit operands):
  - `leak = s >> LEAK_SHIFT`.
  - `sum = s - leak + cur`, computed in W+1 bits and saturated to 2^W-1.
  - `delta = {0,new} - {0,last[i]}`, signed W+1 bits.
  - spike iff `delta >= DELTA_THRESH` (signed compare; negative deltas never spike).
  - `ev_delta = delta[W-1:0]`.
  - `last[i]` is updated to `new` only when an event is emitted.
- `state[]` and `last[]` are N-entry register arrays. They reset to 0 and are never cleared otherwise.
- `step` while busy: ignored, sets `overrun`. Only reset clears `overrun`.
- `step` in the DONE cycle is also ignored and sets `overrun`.
- `ev_idx`/`ev_delta` are stable while `ev_valid`=1 and `ev_ready`=0. `ev_valid` never drops without a handshake.
- `busy` = FSM not in IDLE.
- `cur_idx` = i in every state. It is 0 in IDLE.

## Timing
- Reset values:
  - FSM IDLE, i=0.
  - All outputs 0: `cur_idx`, `ev_valid`, `ev_idx`, `ev_delta`, `busy`, `done`, `overrun`, `dbg_state`.
  - All state/last entries 0.
- `step` high at edge k -> FETCH in cycle k+1, UPDATE in cycle k+2.
- With an event, `ev_valid` is registered high from cycle k+3 and drops the cycle after the handshake.
- Sweep with no events and no stalls: 2N+1 cycles from FETCH to the `done` pulse.
- Each event adds 1 cycle plus stall cycles.
- `ev_ready` may be high before `ev_valid`. The handshake completes in the first EMIT cycle.
- Reset mid-sweep: everything returns to reset values immediately. A pending event is dropped and partial updates are lost.

## Structure
- Package `delta_liafn_pkg` holds:
  - the FSM state enum (IDLE, FETCH, UPDATE, EMIT, DONE);
  - the default `W`;
  - an event struct `{idx, delta}`.
- Sub-module `delta_neuron_update` is purely combinational: leak, integrate, saturate, delta and spike compare. It has inputs `s`, `cur`, `last` and outputs `new_s`, `delta`, `spike`.
- The top level contains the FSM, index counter, register arrays and output registers.

## Test plan
- Reset: after `rst_n` deasserts, all outputs are 0. A `step` with `cur_in` = 0 for all neurons gives no events and `done` exactly 9 cycles after FETCH starts (N=4).
- Neuron 0 with cur=20, others 0, `ev_ready`=1 -> one event (0,20) and `state[0]`=20.
- Next step, all cur=0 -> `state[0]`=15 (delta -5), no event. The step after that -> 12, no event.
- Saturation: neuron 1 driven to 250, then cur=100 -> state 255. With last=250, delta 5, no event.
- Backpressure: on event (0,20) hold `ev_ready`=0 for 5 cycles -> `ev_valid`, `ev_idx`, `ev_delta` stable and `cur_idx` frozen. Release -> sweep resumes and `done` arrives 5 cycles later than unstalled.
- `step` pulsed mid-sweep -> `overrun`=1 stays set and the sweep count is unchanged. Asserting `rst_n`=0 during EMIT -> `ev_valid`, `busy`, `overrun` = 0 and `state[]` = 0.
